// File: rtl/div_pkg.sv
// Shared types and constants for the iterative RV32M divider.
package div_pkg;

  localparam int unsigned DIV_W     = 32;
  localparam int unsigned DIV_ITERS = 32;
  localparam int unsigned CNT_W     = $clog2(DIV_ITERS);

  localparam logic [DIV_W-1:0] DIV_ALL_ONES = 32'hFFFF_FFFF;
  localparam logic [DIV_W-1:0] DIV_MIN_INT  = 32'h8000_0000;

  // Encodings match funct3[1:0]
  typedef enum logic [1:0] {
    DIV_OP_DIV  = 2'b00,
    DIV_OP_DIVU = 2'b01,
    DIV_OP_REM  = 2'b10,
    DIV_OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREP = 3'd1,
    ST_ITER = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } div_state_e;

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op == DIV_OP_DIV) || (op == DIV_OP_REM);
  endfunction

  function automatic logic op_is_rem(input logic [1:0] op);
    return (op == DIV_OP_REM) || (op == DIV_OP_REMU);
  endfunction

endpackage

// File: rtl/div_sign_unit.sv
// Conditional two's-complement negate: abs in PREP, sign restore in FIX.
module div_sign_unit
  import div_pkg::*;
(
  input  logic             neg,
  input  logic [DIV_W-1:0] a,
  output logic [DIV_W-1:0] y
);

  assign y = neg ? (~a + DIV_W'(1)) : a;

endmodule

// File: rtl/dsp_add32.sv
// 32-bit DSP adder used for the divider's trial subtraction.
module dsp_add32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] sum
);

  assign sum = a + b;

endmodule

// File: rtl/div_iter.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Optional DIV_FAST_SPECIAL_EN: divide-by-zero and signed overflow skip the iterations.
module div_iter
  import div_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [DIV_W-1:0] dividend,
  input  logic [DIV_W-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DIV_W-1:0] result,
  output logic             busy
);

  div_state_e       state;
  logic [1:0]       op_r;
  logic [DIV_W-1:0] dvd_r;
  logic [DIV_W-1:0] dvs_r;
  logic [DIV_W-1:0] abs_d;
  logic [DIV_W-1:0] neg_d;
  logic [DIV_W-1:0] rem;
  logic [DIV_W-1:0] quo;
  logic [CNT_W-1:0] cnt;
  logic             sign_q;
  logic             sign_r;

  logic [DIV_W-1:0] sh;
  logic [DIV_W-1:0] sum;
  logic             ge;
  logic             is_signed;
  logic             dvs_zero;
  logic             sa_neg;
  logic             sb_neg;
  logic [DIV_W-1:0] sa_in;
  logic [DIV_W-1:0] sb_in;
  logic [DIV_W-1:0] sa_out;
  logic [DIV_W-1:0] sb_out;

  assign is_signed = op_is_signed(op_r);
  assign dvs_zero  = (dvs_r == '0);

`ifdef DIV_FAST_SPECIAL_EN
  logic ovf;
  assign ovf = is_signed && (dvd_r == DIV_MIN_INT) && (dvs_r == DIV_ALL_ONES);
`endif

  // Trial subtraction: shifted partial remainder plus -|divisor|
  assign sh = {rem[DIV_W-2:0], quo[DIV_W-1]};
  assign ge = (sh >= abs_d);

  dsp_add32 u_add (
    .a   (sh),
    .b   (neg_d),
    .sum (sum)
  );

  // Sign units take operands in PREP and quotient/remainder in FIX
  always_comb begin
    sa_in  = dvd_r;
    sa_neg = is_signed & dvd_r[DIV_W-1];
    sb_in  = dvs_r;
    sb_neg = is_signed & dvs_r[DIV_W-1];
    if (state == ST_FIX) begin
      sa_in  = quo;
      sa_neg = sign_q;
      sb_in  = rem;
      sb_neg = sign_r;
    end
  end

  div_sign_unit u_sign_a (
    .neg (sa_neg),
    .a   (sa_in),
    .y   (sa_out)
  );

  div_sign_unit u_sign_b (
    .neg (sb_neg),
    .a   (sb_in),
    .y   (sb_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      result    <= '0;
      op_r      <= '0;
      dvd_r     <= '0;
      dvs_r     <= '0;
      abs_d     <= '0;
      neg_d     <= '0;
      rem       <= '0;
      quo       <= '0;
      cnt       <= '0;
      sign_q    <= 1'b0;
      sign_r    <= 1'b0;
    end else if (flush) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            op_r     <= op;
            dvd_r    <= dividend;
            dvs_r    <= divisor;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= ST_PREP;
          end
        end

        ST_PREP: begin
          abs_d  <= sb_out;
          neg_d  <= ~sb_out + DIV_W'(1);
          rem    <= '0;
          quo    <= sa_out;
          // Divide-by-zero keeps an all-ones quotient regardless of dividend sign
          sign_q <= is_signed & (dvd_r[DIV_W-1] ^ dvs_r[DIV_W-1]) & ~dvs_zero;
          sign_r <= is_signed & dvd_r[DIV_W-1];
          cnt    <= CNT_W'(DIV_ITERS - 1);
          state  <= ST_ITER;
`ifdef DIV_FAST_SPECIAL_EN
          if (dvs_zero || ovf) begin
            quo    <= dvs_zero ? DIV_ALL_ONES : DIV_MIN_INT;
            rem    <= dvs_zero ? dvd_r : '0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
            state  <= ST_FIX;
          end
`endif
        end

        ST_ITER: begin
          rem <= ge ? sum : sh;
          quo <= {quo[DIV_W-2:0], ge};
          cnt <= cnt - CNT_W'(1);
          if (cnt == '0) begin
            state <= ST_FIX;
          end
        end

        ST_FIX: begin
          result    <= op_is_rem(op_r) ? sb_out : sa_out;
          out_valid <= 1'b1;
          state     <= ST_DONE;
        end

        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            state     <= ST_IDLE;
          end
        end

        default: begin
          state     <= ST_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_iter.sv
// Scoreboard bench for div_iter: driver queues expected results, monitor checks them on out_valid.
module tb_div_iter;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  op;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        busy;

  localparam int LAT_N = 34;
`ifdef DIV_FAST_SPECIAL_EN
  localparam int LAT_S = 2;
`else
  localparam int LAT_S = 34;
`endif

  typedef struct {
    logic [31:0] res;
    int          due;
    string       nm;
  } exp_t;

  exp_t sb[$];
  int   n_cmp;
  int   n_bad;
  int   n_rise;
  int   cyc;
  logic prev_ov;

  div_iter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out at cycle %0d", nm, cyc);
  endtask

  // Monitor: pop and compare on every rising out_valid
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_ov = 1'b0;
    end else begin
      if (out_valid && !prev_ov) begin
        exp_t e;
        n_rise++;
        if (sb.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_out: got %h expected no output", result);
        end else begin
          e = sb.pop_front();
          chk({e.nm, "_res"}, result, e.res);
          chk({e.nm, "_lat"}, 32'(cyc), 32'(e.due));
        end
      end
      prev_ov = out_valid;
    end
  end

  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input int lat, input bit track,
                       input string nm, output int k);
    int t;
    t = 0;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) timeout({nm, "_ready"});
    op       = o;
    dividend = a;
    divisor  = b;
    in_valid = 1'b1;
    k        = cyc + 1;
    if (track) sb.push_back('{exp, k + lat, nm});
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    int t;
    t = 0;
    while ((sb.size() != 0 || out_valid) && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0 || out_valid) timeout({nm, "_done"});
  endtask

  task automatic run(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp, input int lat, input string nm);
    int k;
    issue(o, a, b, exp, lat, 1'b1, nm, k);
    wait_done(nm);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    int k;
    int rises;
    int t;
    n_cmp     = 0;
    n_bad     = 0;
    n_rise    = 0;
    cyc       = 0;
    prev_ov   = 1'b0;
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    op        = 2'b00;
    dividend  = '0;
    divisor   = '0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_result", result, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    run(2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, LAT_N, "div_m7_2");
    run(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, LAT_N, "rem_m7_2");
    run(2'b00, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, LAT_N, "div_7_m2");
    run(2'b10, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, LAT_N, "rem_m7_m2");
    run(2'b01, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, LAT_N, "divu_max_1");
    run(2'b11, 32'd100, 32'd7, 32'd2, LAT_N, "remu_100_7");
    run(2'b01, 32'h1234_5678, 32'h10, 32'h0123_4567, LAT_N, "divu_hex_16");
    run(2'b00, 32'd5, 32'd0, 32'hFFFF_FFFF, LAT_S, "div_5_0");
    run(2'b10, 32'd5, 32'd0, 32'd5, LAT_S, "rem_5_0");
    run(2'b01, 32'd5, 32'd0, 32'hFFFF_FFFF, LAT_S, "divu_5_0");
    run(2'b11, 32'd5, 32'd0, 32'd5, LAT_S, "remu_5_0");
    run(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT_S, "div_ovf");
    run(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, LAT_S, "rem_ovf");

    // Flush during the tenth iteration
    rises = n_rise;
    issue(2'b01, 32'd100, 32'd7, 32'd0, LAT_N, 1'b0, "flush_op", k);
    t = 0;
    while (cyc < k + 10 && t < 100) begin
      @(negedge clk);
      t++;
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_busy", 32'(busy), 32'd0);
    chk("flush_in_ready", 32'(in_ready), 32'd1);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    repeat (40) @(negedge clk);
    chk("flush_no_output", 32'(n_rise), 32'(rises));
    run(2'b01, 32'd9, 32'd3, 32'd3, LAT_N, "divu_9_3");

    // Flush together with in_valid in IDLE is not accepted
    rises    = n_rise;
    op       = 2'b01;
    dividend = 32'd9;
    divisor  = 32'd3;
    in_valid = 1'b1;
    flush    = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    flush    = 1'b0;
    chk("idle_flush_busy", 32'(busy), 32'd0);
    chk("idle_flush_in_ready", 32'(in_ready), 32'd1);
    repeat (40) @(negedge clk);
    chk("idle_flush_no_output", 32'(n_rise), 32'(rises));

    // Backpressure in DONE
    out_ready = 1'b0;
    issue(2'b11, 32'd100, 32'd7, 32'd2, LAT_N, 1'b1, "hold_remu", k);
    t = 0;
    while (!out_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!out_valid) timeout("hold_wait");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_result", result, 32'd2);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_out_valid", 32'(out_valid), 32'd1);
    end
    out_ready = 1'b1;
    @(negedge clk);
    chk("release_in_ready", 32'(in_ready), 32'd1);
    chk("release_out_valid", 32'(out_valid), 32'd0);
    chk("release_busy", 32'(busy), 32'd0);

    // Asynchronous reset mid-operation
    rises = n_rise;
    issue(2'b00, 32'hFFFF_FFF9, 32'd2, 32'd0, LAT_N, 1'b0, "rst_op", k);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_result", result, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("midrst_no_output", 32'(n_rise), 32'(rises));
    run(2'b11, 32'd100, 32'd7, 32'd2, LAT_N, "post_rst_remu");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
